// File: rtl/bus_arb_pkg.sv
// Shared types and default constants for the datapath bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM: IDLE = no owner, OWN = exactly one requester holds the bus
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 18;
  localparam int MAX_HOLD_DEF = 16;

  // Index width for n requesters, never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at rr_ptr,
// rr_ptr+1, ... wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [SEL_W-1:0]   win_idx,
  output logic               found
);

  // Scan from the pointer; the first hit wins and later hits are ignored
  always_comb begin
    int idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and source mux for the shared datapath bus.
// Optional feature: define BUS_TIMEOUT_EN to bound ownership to MAX_HOLD
// cycles; a timed-out requester is masked until it drops its request once.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEL_W    = sel_width(NUM_REQ),
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [SEL_W-1:0]          bus_sel,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic                      busy,
  output logic                      timeout
);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic               tmo_reg;

  logic [NUM_REQ-1:0] mask_eff;
  logic               owner_req;
  logic               expire;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] win;
  logic [SEL_W-1:0]   win_idx;
  logic               found;
  logic [SEL_W-1:0]   ptr_inc;
  logic [DATA_W-1:0]  slot [NUM_REQ];

  // Current owner still wants the bus (grant_reg is zero in IDLE)
  assign owner_req = |(req & grant_reg);

  // The current owner never competes in its own handover
  assign pick_req = req & ~mask_eff & ~grant_reg;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req    (pick_req),
    .rr_ptr (ptr_reg),
    .win    (win),
    .win_idx(win_idx),
    .found  (found)
  );

  assign ptr_inc = (win_idx == SEL_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef BUS_TIMEOUT_EN
  localparam int HOLD_W = sel_width(MAX_HOLD);

  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [NUM_REQ-1:0] mask_reg, mask_next;

  assign expire   = owner_req && (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign mask_eff = mask_reg;

  // Hold counter restarts on every new grant; mask clears once req is seen low
  always_comb begin
    hold_cnt_next = '0;
    if (owner_req && !expire) begin
      hold_cnt_next = (hold_cnt_reg == '1) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
    end
    mask_next = (mask_reg & req) | (expire ? grant_reg : '0);
  end

  // Timeout bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_reg <= '0;
      mask_reg     <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      mask_reg     <= mask_next;
    end
  end
`else
  assign expire   = 1'b0;
  assign mask_eff = '0;
`endif

  // Next-state: grant from IDLE, keep, or hand over with no dead cycle
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = win;
          sel_next   = win_idx;
          ptr_next   = ptr_inc;
          state_next = OWN;
        end
      end
      OWN: begin
        if (!owner_req || expire) begin
          if (found) begin
            grant_next = win;
            sel_next   = win_idx;
            ptr_next   = ptr_inc;
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Arbitration state registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      tmo_reg   <= expire;
    end
  end

  // Unpack flattened source data into per-requester slots
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign slot[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  assign grant     = grant_reg;
  assign bus_sel   = sel_reg;
  assign bus_valid = |grant_reg;
  assign busy      = (state_reg == OWN);
  assign timeout   = tmo_reg;
  assign bus_out   = bus_valid ? slot[sel_reg] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: expected results are queued as each
// stimulus step is driven and compared one cycle later.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [71:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  bus_sel;
  logic [17:0] bus_out;
  logic        bus_valid;
  logic        busy;
  logic        timeout;

  typedef struct packed {
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [17:0] data;
    logic        valid;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] slot_data [4];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_step   = 0;

  bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .bus_sel  (bus_sel),
    .bus_out  (bus_out),
    .bus_valid(bus_valid),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive req at a negedge, queue the expected result, compare after the edge
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                      input logic et);
    exp_t e;
    req     = r;
    e.grant = eg;
    e.sel   = es;
    e.valid = |eg;
    e.data  = (|eg) ? slot_data[es] : 18'h0;
    e.tmo   = et;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_step++;
    check_eq("grant",   32'(grant),     32'(e.grant));
    check_eq("valid",   32'(bus_valid), 32'(e.valid));
    check_eq("busy",    32'(busy),      32'(e.valid));
    check_eq("bus_out", 32'(bus_out),   32'(e.data));
    check_eq("timeout", 32'(timeout),   32'(e.tmo));
    if (e.valid) check_eq("bus_sel", 32'(bus_sel), 32'(e.sel));
    $display("step %0d req=%b grant=%b sel=%0d bus_out=%h valid=%b busy=%b timeout=%b",
             n_step, r, grant, bus_sel, bus_out, bus_valid, busy, timeout);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_data[0] = 18'h01234;
    slot_data[1] = 18'h15678;
    slot_data[2] = 18'h2ABCD;
    slot_data[3] = 18'h3F00F;
    req_data = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};

    // 1. Reset with all requests pending
    rst = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant",   32'(grant),     32'h0);
    check_eq("rst_bus_out", 32'(bus_out),   32'h0);
    check_eq("rst_valid",   32'(bus_valid), 32'h0);
    check_eq("rst_busy",    32'(busy),      32'h0);
    check_eq("rst_timeout", 32'(timeout),   32'h0);
    check_eq("rst_bus_sel", 32'(bus_sel),   32'h0);
    $display("reset grant=%b bus_out=%h", grant, bus_out);
    @(negedge clk);
    rst = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b0);

    // 2. Round-robin order 0,1,2,3,0 with no idle cycles, then go idle
    step(4'b1110, 4'b0010, 2'd1, 1'b0);
    step(4'b1101, 4'b0100, 2'd2, 1'b0);
    step(4'b1011, 4'b1000, 2'd3, 1'b0);
    step(4'b0111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 3. Data path: only requester 2
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 4. Handover: owner 1 holds 5 cycles while 3 pends; pointer then at 0
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1010, 4'b0010, 2'd1, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // 5. Ownership limit
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step(4'b0011, 4'b0001, 2'd0, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1);
    step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
`else
    for (int i = 0; i < 20; i++) step(4'b0011, 4'b0001, 2'd0, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
`endif

    // 6. Asynchronous reset in the middle of ownership
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_grant",   32'(grant),     32'h0);
    check_eq("arst_valid",   32'(bus_valid), 32'h0);
    check_eq("arst_busy",    32'(busy),      32'h0);
    check_eq("arst_bus_out", 32'(bus_out),   32'h0);
    $display("async reset grant=%b valid=%b busy=%b", grant, bus_valid, busy);
    @(negedge clk);
    rst = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
